// File: rtl/vx_mul_pipe_ctrl.sv
// Valid/ready control shell around an enable-gated signed multiplier for RISC-V MUL/MULH/MULHSU/MULHU.
// Define MUL_OUT_BUF_EN to insert a registered 2-entry skid buffer between the pipeline tail and the output port.
module vx_mul_pipe_ctrl #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [TAG_WIDTH-1:0] out_tag
);

  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} mul_op_e;

  if (LATENCY < 0 || LATENCY > 3) begin : g_bad_latency
    $error("vx_mul_pipe_ctrl: LATENCY must be in 0..3");
  end

  mul_op_e              op;
  logic                 a_signed, b_signed, hi_sel;
  logic [WIDTH:0]       a_ext, b_ext;
  logic [2*WIDTH-1:0]   a_wide, b_wide, product;

  logic                 tail_valid, tail_ready;
  logic [WIDTH-1:0]     tail_data;
  logic [TAG_WIDTH-1:0] tail_tag;

  // NOTE: every always_comb output gets a default on entry, so no path leaves a latch behind.
  always_comb begin
    op       = mul_op_e'(in_op);
    a_signed = (op != OP_MULHU);
    b_signed = (op == OP_MUL) || (op == OP_MULH);
    hi_sel   = (op != OP_MUL);
    a_ext    = {a_signed & in_a[WIDTH-1], in_a};
    b_ext    = {b_signed & in_b[WIDTH-1], in_b};
    // Signed (WIDTH+1)-bit product truncated to 2*WIDTH: sign-extend both operands to the result width.
    a_wide   = {{(WIDTH-1){a_ext[WIDTH]}}, a_ext};
    b_wide   = {{(WIDTH-1){b_ext[WIDTH]}}, b_ext};
  end

  if (LATENCY == 0) begin : g_comb
    assign product    = a_wide * b_wide;
    assign tail_valid = in_valid;
    assign tail_tag   = in_tag;
    assign tail_data  = hi_sel ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
    assign in_ready   = tail_ready && reset_n;
  end else begin : g_pipe
    logic                 enable;
    logic [LATENCY-1:0]   valid_q, valid_d, hi_q, hi_d;
    logic [TAG_WIDTH-1:0] tag_q  [LATENCY];
    logic [TAG_WIDTH-1:0] tag_d  [LATENCY];
    logic [2*WIDTH-1:0]   prod_q [LATENCY];
    logic [2*WIDTH-1:0]   prod_d [LATENCY];

    assign product = a_wide * b_wide;
    // One enable moves product and metadata together, so they can never drift apart.
    assign enable  = !(tail_valid && !tail_ready);
    assign in_ready = enable && reset_n;

    always_comb begin
      valid_d = valid_q;
      hi_d    = hi_q;
      tag_d   = tag_q;
      prod_d  = prod_q;
      if (enable) begin
        valid_d[0] = in_valid;
        hi_d[0]    = hi_sel;
        tag_d[0]   = in_tag;
        prod_d[0]  = product;
        for (int i = 1; i < LATENCY; i++) begin
          valid_d[i] = valid_q[i-1];
          hi_d[i]    = hi_q[i-1];
          tag_d[i]   = tag_q[i-1];
          prod_d[i]  = prod_q[i-1];
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) valid_q <= '0;
      else          valid_q <= valid_d;
    end

    // NOTE: payload registers carry no reset; the valid bits alone decide whether their contents matter.
    always_ff @(posedge clk) begin
      hi_q   <= hi_d;
      tag_q  <= tag_d;
      prod_q <= prod_d;
    end

    assign tail_valid = valid_q[LATENCY-1];
    assign tail_tag   = tag_q[LATENCY-1];
    assign tail_data  = hi_q[LATENCY-1] ? prod_q[LATENCY-1][2*WIDTH-1:WIDTH]
                                        : prod_q[LATENCY-1][WIDTH-1:0];
  end

`ifdef MUL_OUT_BUF_EN
  logic [1:0]           cnt_q, cnt_d;
  logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 push, pop;
  logic [WIDTH-1:0]     buf_data_q [2];
  logic [WIDTH-1:0]     buf_data_d [2];
  logic [TAG_WIDTH-1:0] buf_tag_q  [2];
  logic [TAG_WIDTH-1:0] buf_tag_d  [2];

  // Readiness toward the pipe comes only from registered occupancy, breaking the out_ready -> in_ready path.
  always_comb begin
    tail_ready = (cnt_q != 2'd2);
    push       = tail_valid && tail_ready;
    pop        = (cnt_q != 2'd0) && out_ready;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    buf_data_d = buf_data_q;
    buf_tag_d  = buf_tag_q;
    if (push) begin
      buf_data_d[wr_ptr_q] = tail_data;
      buf_tag_d[wr_ptr_q]  = tail_tag;
      wr_ptr_d             = !wr_ptr_q;
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_tag_q  <= buf_tag_d;
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_tag   = buf_tag_q[rd_ptr_q];
`else
  assign tail_ready = out_ready;
  assign out_valid  = tail_valid && reset_n;
  assign out_data   = tail_data;
  assign out_tag    = tail_tag;
`endif

endmodule

// File: tb/tb_vx_mul_pipe_ctrl.sv
// Self-checking bench for vx_mul_pipe_ctrl: three instances (LATENCY 0, 2, 3) driven one at a time,
// directed steps plus random sweeps scored against an arithmetic reference queue.
module tb_vx_mul_pipe_ctrl;

  localparam int BUF =
`ifdef MUL_OUT_BUF_EN
    1;
`else
    0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [7:0]  tag;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  in_valid, out_ready;
  logic [1:0]  in_op  [3];
  logic [31:0] in_a   [3];
  logic [31:0] in_b   [3];
  logic [7:0]  in_tag [3];
  wire  [2:0]  in_ready, out_valid;
  wire  [31:0] out_data [3];
  wire  [7:0]  out_tag  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vx_mul_pipe_ctrl #(
      .WIDTH(32), .TAG_WIDTH(8), .LATENCY(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_op(in_op[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .in_tag(in_tag[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_data(out_data[g]), .out_tag(out_tag[g])
    );
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        exp_q [$];
  logic [31:0] got_data [$];
  logic [7:0]  got_tag  [$];
  int          got_cyc  [$];
  logic        last_acc, last_drn, last_ir;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [7:0]  prev_tag;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  // Reference: exact product of the extended operands, modulo 2^64, then pick the word.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'd3) ? {32'd0, a} : {{32{a[31]}}, a};
    eb = (op <= 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [7:0] tag);
    in_op[k] = op; in_a[k] = a; in_b[k] = b; in_tag[k] = tag; in_valid[k] = 1'b1;
  endtask

  task automatic new_req(input int k, input logic [7:0] tag);
    set_req(k, 2'($urandom_range(3)), rand_operand(), rand_operand(), tag);
  endtask

  task automatic clear_results();
    exp_q.delete(); got_data.delete(); got_tag.delete(); got_cyc.delete();
    prev_stall = 1'b0;
  endtask

  // One clock of DUT k: observe at the falling edge, score, then advance past the rising edge.
  task automatic tick(input int k);
    exp_t        e;
    logic        ov;
    logic [31:0] od;
    logic [7:0]  ot;
    @(negedge clk);
    ov = out_valid[k]; od = out_data[k]; ot = out_tag[k]; last_ir = in_ready[k];
    last_acc = in_valid[k] && last_ir;
    last_drn = ov && out_ready[k];
    if (prev_stall) begin
      check("stall_valid_held", ov, 1'b1);
      check("stall_data_held", od, prev_data);
      check("stall_tag_held", ot, prev_tag);
    end
`ifndef MUL_OUT_BUF_EN
    check("in_ready_rule", last_ir, (lat_of(k) == 0) ? out_ready[k] : (!ov || out_ready[k]));
`endif
    if (last_acc) begin
      e.data = ref_result(in_op[k], in_a[k], in_b[k]);
      e.tag  = in_tag[k];
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
    if (k == 0 && BUF == 0) check("l0_valid_passthru", ov, in_valid[k]);
    else if (exp_q.size() == 0) check("no_spurious_valid", ov, 1'b0);
    if (last_drn && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("out_data", od, e.data);
      check("out_tag", ot, e.tag);
      check("latency_min", (cyc - e.cyc) >= (lat_of(k) + BUF), 1'b1);
      got_data.push_back(od); got_tag.push_back(ot); got_cyc.push_back(cyc);
    end
    prev_stall = ov && !out_ready[k];
    prev_data  = od;
    prev_tag   = ot;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain_all(input int k, input int budget);
    int n = 0;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick(k);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic sweep(input int k, input int n_ops);
    int acc = 0;
    int t   = 0;
    clear_results();
    in_valid[k] = 1'b0;
    while (acc < n_ops && t < 20 * n_ops) begin
      if (!in_valid[k] && $urandom_range(3) != 0) new_req(k, 8'($urandom));
      out_ready[k] = ($urandom_range(3) != 0);
      tick(k);
      if (last_acc) begin
        acc++;
        in_valid[k] = 1'b0;
      end
      t++;
    end
    check("sweep_accepted", acc, n_ops);
    drain_all(k, 50);
    check("sweep_results", got_data.size(), n_ops);
  endtask

  initial begin
    int  acc_cyc, idx, t;
    logic saw_low, stalled;

    // Reset with requests asserted everywhere: nothing may be offered or accepted.
    reset_n = 1'b0;
    in_valid = 3'b111;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) set_req(k, 2'd0, 32'd5, 32'd6, 8'h00);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_out_valid", out_valid[k], 1'b0);
      check("reset_in_ready", in_ready[k], 1'b0);
    end
    in_valid = 3'b000;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single MUL with a negative operand, exact latency.
    clear_results();
    set_req(1, 2'd0, 32'd7, 32'hFFFF_FFFD, 8'h11);
    acc_cyc = cyc;
    tick(1);
    check("t1_accept", last_acc, 1'b1);
    drain_all(1, 10);
    check("t1_count", got_data.size(), 1);
    if (got_data.size() == 1) begin
      check("t1_data", got_data[0], 32'hFFFF_FFEB);
      check("t1_tag", got_tag[0], 8'h11);
      check("t1_latency", got_cyc[0] - acc_cyc, lat_of(1) + BUF);
    end

    // Back-to-back high-word ops including the most-negative corner.
    clear_results();
    set_req(1, 2'd1, 32'h8000_0000, 32'h8000_0000, 8'h01); tick(1); check("b2b_acc0", last_acc, 1'b1);
    set_req(1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h02); tick(1); check("b2b_acc1", last_acc, 1'b1);
    set_req(1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 8'h03); tick(1); check("b2b_acc2", last_acc, 1'b1);
    drain_all(1, 10);
    check("b2b_count", got_data.size(), 3);
    if (got_data.size() == 3) begin
      check("b2b_mulh", got_data[0], 32'h4000_0000);
      check("b2b_mulhu", got_data[1], 32'hFFFF_FFFE);
      check("b2b_mulhsu", got_data[2], 32'hFFFF_FFFF);
      check("b2b_consec1", got_cyc[1] - got_cyc[0], 1);
      check("b2b_consec2", got_cyc[2] - got_cyc[1], 1);
    end

    // Eight requests with the sink stalled during cycles 3..7.
    clear_results();
    idx = 0; t = 0; saw_low = 1'b0;
    in_valid[1] = 1'b0;
    while ((idx < 8 || exp_q.size() != 0) && t < 60) begin
      if (idx < 8 && !in_valid[1]) new_req(1, 8'h20 + 8'(idx));
      out_ready[1] = !(t >= 3 && t <= 7);
      tick(1);
      if (in_valid[1] && !last_ir) saw_low = 1'b1;
      if (last_acc) begin
        idx++;
        in_valid[1] = 1'b0;
      end
      t++;
    end
    check("bp_in_ready_fell", saw_low, 1'b1);
    check("bp_count", got_data.size(), 8);
    for (int i = 0; i < 8 && i < got_tag.size(); i++) check("bp_tag_order", got_tag[i], 8'h20 + 8'(i));

    // Fill the pipe against a stalled sink, then release the sink together with a new request.
    clear_results();
    out_ready[1] = 1'b0;
    stalled = 1'b0;
    new_req(1, 8'h40);
    for (int i = 0; i < 10 && !stalled; i++) begin
      tick(1);
      if (last_acc) new_req(1, 8'h41 + 8'(i));
      else stalled = 1'b1;
    end
    check("fill_stalled", last_ir, 1'b0);
    out_ready[1] = 1'b1;
    tick(1);
`ifndef MUL_OUT_BUF_EN
    check("simul_accept", last_acc, 1'b1);
`endif
    check("simul_drain", last_drn, 1'b1);
    for (int i = 0; i < 5 && !last_acc; i++) tick(1);
    drain_all(1, 20);

    // Asynchronous reset with two operations in flight, the older one already at the output.
    clear_results();
    out_ready[1] = 1'b1;
    new_req(1, 8'h60); tick(1);
    new_req(1, 8'h61); tick(1);
    in_valid[1] = 1'b0;
    for (int i = 0; i < BUF; i++) tick(1);
    #1;
    check("pre_rst_out_valid", out_valid[1], 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_async_out_valid", out_valid[1], 1'b0);
    check("rst_async_in_ready", in_ready[1], 1'b0);
    clear_results();
    new_req(1, 8'h62);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_out_valid", out_valid[1], 1'b0);
      check("rst_hold_in_ready", in_ready[1], 1'b0);
    end
    in_valid[1] = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    repeat (6) tick(1);
    check("post_rst_no_stale", got_data.size(), 0);
    set_req(1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h63);
    tick(1);
    check("post_rst_accept", last_acc, 1'b1);
    drain_all(1, 10);
    check("post_rst_count", got_data.size(), 1);
    if (got_data.size() == 1) check("post_rst_data", got_data[0], 32'h0000_0001);

    // Random sweeps with random backpressure.
    sweep(0, 1000);
    sweep(2, 1000);
    sweep(1, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
